// File: rtl/serdesphy_rx_align.sv
// serdesphy_rx_align: receive-side comma hunter, symbol aligner and nibble decoder.
// The serial stream arrives MSB-first. The block hunts bit by bit for COMMA and
// confirms alignment with LOCK_CNT commas that fall on the symbol boundary. Once
// locked it decodes {2'b10, d, ~d} symbols to nibbles. Every output is registered.
module serdesphy_rx_align #(
    parameter logic [9:0]  COMMA     = 10'b0011111010,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_LIMIT = 4
) (
    input  logic       clk_240m_rx,
    input  logic       rst_n_240m_rx,
    input  logic       rx_en,
    input  logic       rx_align_rst,
    input  logic       rx_serial_data,
    input  logic       rx_serial_valid,
    output logic [3:0] rx_data,
    output logic       rx_valid,
    output logic       rx_idle,
    output logic       rx_aligned,
    output logic       rx_error,
    output logic [7:0] sym_err_cnt
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);

    state_t     state_q, state_d;
    logic [9:0] sr_q, sr_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [3:0] bad_cnt_q, bad_cnt_d;
    logic [3:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_idle_q, rx_idle_d;
    logic       rx_aligned_q, rx_aligned_d;
    logic       rx_error_q, rx_error_d;
    logic [7:0] sym_err_cnt_q, sym_err_cnt_d;

    logic [9:0] nxt;
    logic       sym_done;
    logic       is_comma;
    logic       is_data;

    // The symbol that would sit in the shift register once the current bit is taken.
    assign nxt      = {sr_q[8:0], rx_serial_data};
    assign sym_done = (bit_cnt_q == 4'd9);
    assign is_comma = (nxt == COMMA);
    assign is_data  = (nxt[9:8] == 2'b10) && (nxt[3:0] == ~nxt[7:4]);

    // Next-state logic: the control overrides take priority over bit processing.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        comma_cnt_d   = comma_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_idle_d     = 1'b0;
        rx_error_d    = 1'b0;
        rx_aligned_d  = rx_aligned_q;
        sym_err_cnt_d = sym_err_cnt_q;

        if (rx_align_rst || !rx_en) begin
            state_d      = HUNT;
            sr_d         = '0;
            bit_cnt_d    = '0;
            comma_cnt_d  = '0;
            bad_cnt_d    = '0;
            rx_aligned_d = 1'b0;
            // Disabling the aligner holds the error history; only an alignment reset clears it.
            if (rx_align_rst) sym_err_cnt_d = '0;
        end else if (rx_serial_valid) begin
            sr_d      = nxt;
            bit_cnt_d = sym_done ? 4'd0 : bit_cnt_q + 4'd1;
            unique case (state_q)
                HUNT: begin
                    // The bit counter is anchored by the comma that ends here.
                    bit_cnt_d = '0;
                    if (is_comma) begin
                        comma_cnt_d = 4'd1;
                        bad_cnt_d   = '0;
                        if (LOCK_N == 4'd1) begin
                            state_d      = LOCKED;
                            rx_aligned_d = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (sym_done) begin
                        if (is_comma) begin
                            comma_cnt_d = comma_cnt_q + 4'd1;
                            if (comma_cnt_q + 4'd1 >= LOCK_N) begin
                                state_d      = LOCKED;
                                rx_aligned_d = 1'b1;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (sym_done) begin
                        if (is_comma) begin
                            rx_idle_d = 1'b1;
                            bad_cnt_d = '0;
                        end else if (is_data) begin
                            rx_data_d  = nxt[7:4];
                            rx_valid_d = 1'b1;
                            bad_cnt_d  = '0;
                        end else begin
                            rx_error_d = 1'b1;
                            if (sym_err_cnt_q != 8'hFF) sym_err_cnt_d = sym_err_cnt_q + 8'd1;
                            bad_cnt_d = bad_cnt_q + 4'd1;
                            // The lock drops on the same edge as the strobe of the last bad symbol.
                            if (bad_cnt_q + 4'd1 >= ERR_N) begin
                                state_d      = HUNT;
                                rx_aligned_d = 1'b0;
                                bad_cnt_d    = '0;
                                comma_cnt_d  = '0;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // All state and output registers, cleared asynchronously.
    always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
        if (!rst_n_240m_rx) begin
            state_q       <= HUNT;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            comma_cnt_q   <= '0;
            bad_cnt_q     <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_idle_q     <= 1'b0;
            rx_aligned_q  <= 1'b0;
            rx_error_q    <= 1'b0;
            sym_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            comma_cnt_q   <= comma_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_idle_q     <= rx_idle_d;
            rx_aligned_q  <= rx_aligned_d;
            rx_error_q    <= rx_error_d;
            sym_err_cnt_q <= sym_err_cnt_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_idle     = rx_idle_q;
    assign rx_aligned  = rx_aligned_q;
    assign rx_error    = rx_error_q;
    assign sym_err_cnt = sym_err_cnt_q;

endmodule
